// File: rtl/seg_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller:
// digit count, controller state type and the active-low hex segment table.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Bit order {g,f,e,d,c,b,a}, 0 = segment lit.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 4-digit hex display scanner with frame-synchronous update.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
//
// state   | meaning
// ST_OFF  | display blanked, counters held at 0, updates always accepted
// ST_SCAN | digits scanned one slot each, updates accepted only at frame boundary
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 200_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam int             PW         = 20;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [1:0]     IDX_LAST   = 2'(NUM_DIGITS - 1);

    state_e         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    shadow_q, shadow_d;
    logic [3:0]     an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic           frame_tick_q, frame_tick_d;

    logic           slot_tick;
    logic           boundary;
    logic           xfer;
    logic           blank_digit;
    logic [3:0]     nib_sel;
    logic [6:0]     nib_seg;

    assign slot_tick = (state_q == ST_SCAN) && (presc_q == PRESC_LAST);
    assign boundary  = slot_tick && (idx_q == IDX_LAST);
    assign upd_ready = (state_q == ST_OFF) || boundary;
    assign xfer      = upd_valid && upd_ready;

    assign nib_sel = shadow_q[{idx_q, 2'b00} +: 4];

    seg_hex_decoder u_dec (
        .nibble_i (nib_sel),
        .seg_o    (nib_seg)
    );

`ifdef SEG_LZB_EN
    // A digit is blank when it and every more significant nibble are zero.
    always_comb begin
        blank_digit = 1'b0;
        case (idx_q)
            2'd3:    blank_digit = (shadow_q[15:12] == 4'h0);
            2'd2:    blank_digit = (shadow_q[15:8]  == 8'h00);
            2'd1:    blank_digit = (shadow_q[15:4]  == 12'h000);
            default: blank_digit = 1'b0;
        endcase
    end
`else
    assign blank_digit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        an_d         = 4'b1111;
        seg_d        = 7'h7F;
        frame_tick_d = boundary;

        if (xfer) begin
            shadow_d = upd_data;
        end

        case (state_q)
            ST_OFF: begin
                presc_d = '0;
                idx_d   = '0;
                if (en) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!en) begin
                    // Partial frame is dropped; the next enable restarts at digit 0.
                    state_d = ST_OFF;
                    presc_d = '0;
                    idx_d   = '0;
                end else begin
                    an_d  = ~(4'b0001 << idx_q);
                    seg_d = blank_digit ? 7'h7F : nib_seg;
                    if (slot_tick) begin
                        presc_d = '0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            an_q         <= 4'b1111;
            seg_q        <= 7'h7F;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller with CLK_DIV=4.
module tb_seg_scan_controller;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic        upd_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    // Pattern for a leading-zero digit above the highest nonzero nibble.
    localparam logic [6:0] LZ = LZB ? 7'h7F : 7'h40;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       ft;
        logic [7:0] dly;   // clocks since previous output change, 0 = unchecked
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [11:0] prev_obs;
    int          cyc;
    int          last_cyc;
    int          checks;
    int          errors;

    seg_scan_controller #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_ready  (upd_ready),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic f, input int d);
        exp_t x;
        x.an  = a;
        x.seg = s;
        x.ft  = f;
        x.dly = 8'(d);
        exp_q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        last_cyc  = 0;
        prev_obs  = {4'hF, 7'h7F, 1'b0};
        rst_n     = 1'b1;
        en        = 1'b1;
        upd_valid = 1'b0;
        upd_data  = 16'h0000;

        // Monitor: every change of {an,seg,frame_tick} consumes one expected entry.
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if ({an, seg, frame_tick} != prev_obs) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: an=%b seg=%h ft=%b at cycle %0d, nothing expected",
                                 an, seg, frame_tick, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.an !== an || e.seg !== seg || e.ft !== frame_tick ||
                            (e.dly != 0 && int'(e.dly) != cyc - last_cyc)) begin
                            errors++;
                            $display("FAIL display_event: got an=%b seg=%h ft=%b after %0d clk, expected an=%b seg=%h ft=%b after %0d clk",
                                     an, seg, frame_tick, cyc - last_cyc, e.an, e.seg, e.ft, e.dly);
                        end
                    end
                    last_cyc = cyc;
                    prev_obs = {an, seg, frame_tick};
                end
            end
        join_none

        // Reset held while enabled
        #1 rst_n = 1'b0;
        step(3);
        check("rst_an", 16'(an), 16'hF);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_ready", 16'(upd_ready), 16'h1);
        check("rst_frame_tick", 16'(frame_tick), 16'h0);

        // Release with en=1: scan all-zero shadow, then drop en at digit 2
        push(4'b1110, 7'h40, 0, 0); push(4'b1101, LZ, 0, 4); push(4'b1011, LZ, 0, 4);
        push(4'b0111, LZ, 0, 4);    push(4'b0111, LZ, 1, 3);
        push(4'b1110, 7'h40, 0, 1); push(4'b1101, LZ, 0, 4); push(4'b1011, LZ, 0, 4);
        push(4'b0111, LZ, 0, 4);    push(4'b0111, LZ, 1, 3);
        push(4'b1110, 7'h40, 0, 1); push(4'b1101, LZ, 0, 4); push(4'b1011, LZ, 0, 4);
        push(4'b1111, 7'h7F, 0, 1);
        rst_n = 1'b1;
        step(42);
        check("ready_mid_frame", 16'(upd_ready), 16'h0);
        en = 1'b0;

        // Update while off is taken at once
        step(2);
        check("ready_off", 16'(upd_ready), 16'h1);
        upd_valid = 1'b1;
        upd_data  = 16'h12AF;
        step(1);
        upd_valid = 1'b0;
        upd_data  = 16'h0000;

        // Scan 12AF; offer 0008 at digit 1 of the second frame
        push(4'b1110, 7'h0E, 0, 0); push(4'b1101, 7'h08, 0, 4); push(4'b1011, 7'h24, 0, 4);
        push(4'b0111, 7'h79, 0, 4); push(4'b0111, 7'h79, 1, 3);
        push(4'b1110, 7'h0E, 0, 1); push(4'b1101, 7'h08, 0, 4); push(4'b1011, 7'h24, 0, 4);
        push(4'b0111, 7'h79, 0, 4); push(4'b0111, 7'h79, 1, 3);
        push(4'b1110, 7'h00, 0, 1); push(4'b1101, LZ, 0, 4);    push(4'b1011, LZ, 0, 4);
        push(4'b0111, LZ, 0, 4);
        push(4'b1111, 7'h7F, 1, 3); push(4'b1111, 7'h7F, 0, 1);
        en = 1'b1;
        step(22);
        check("ready_digit1", 16'(upd_ready), 16'h0);
        upd_valid = 1'b1;
        upd_data  = 16'h0008;
        step(3);
        check("ready_held_digit2", 16'(upd_ready), 16'h0);
        step(7);
        check("ready_boundary", 16'(upd_ready), 16'h1);
        step(1);
        upd_valid = 1'b0;
        upd_data  = 16'h0000;

        // Drop en exactly at a boundary while transferring 0050
        step(15);
        check("ready_boundary_en_fall", 16'(upd_ready), 16'h1);
        en        = 1'b0;
        upd_valid = 1'b1;
        upd_data  = 16'h0050;
        step(1);
        upd_valid = 1'b0;
        upd_data  = 16'h0000;
        step(1);

        // Scan 0050, then reset mid-frame
        push(4'b1110, 7'h40, 0, 0); push(4'b1101, 7'h12, 0, 4); push(4'b1011, LZ, 0, 4);
        push(4'b0111, LZ, 0, 4);    push(4'b0111, LZ, 1, 3);
        push(4'b1110, 7'h40, 0, 1);
        push(4'b1111, 7'h7F, 0, 0);
        en = 1'b1;
        step(18);
        #2 rst_n = 1'b0;
        step(2);
        check("rst2_an", 16'(an), 16'hF);
        check("rst2_seg", 16'(seg), 16'h7F);
        check("rst2_ready", 16'(upd_ready), 16'h1);

        // After reset the shadow is cleared
        push(4'b1110, 7'h40, 0, 0); push(4'b1101, LZ, 0, 4); push(4'b1011, LZ, 0, 4);
        push(4'b0111, LZ, 0, 4);    push(4'b0111, LZ, 1, 3);
        push(4'b1110, 7'h40, 0, 1);
        push(4'b1111, 7'h7F, 0, 1);
        rst_n = 1'b1;
        step(18);
        en = 1'b0;
        step(4);

        check("pending_expected", 16'(exp_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
